// File: rtl/pc_pkg.sv
// pc_pkg: next-PC select codes and error flag bit positions shared by the PC unit.
package pc_pkg;
    localparam logic [2:0] PC_SRC_SEQ = 3'd0;
    localparam logic [2:0] PC_SRC_BR  = 3'd1;
    localparam logic [2:0] PC_SRC_JMP = 3'd2;
    localparam logic [2:0] PC_SRC_REG = 3'd3;
    localparam logic [2:0] PC_SRC_RET = 3'd4;
    localparam int ERR_OVERFLOW  = 0;
    localparam int ERR_UNDERFLOW = 1;
    localparam int ERR_MISALIGN  = 2;
endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack with saturating count.
// Ports: clk, reset (sync, active-low), push_i/pop_i requests, push_data_i,
//        top_o (newest entry), empty_o/full_o from the registered count,
//        overflow_o/underflow_o single-cycle pulses for the sticky flags.
module pc_ras #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] push_data_i,
    output logic [WIDTH-1:0] top_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             overflow_o,
    output logic             underflow_o
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] SP_ONE  = PW'(1);
    localparam logic [PW:0]   CNT_ONE = (PW + 1)'(1);
    localparam logic [PW:0]   CNT_MAX = (PW + 1)'(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0] sp_q, sp_d, top_idx;
    logic [PW:0] cnt_q, cnt_d;
    logic do_pop;
    // sp_q is the next free slot; the newest entry sits just below it.
    assign top_idx = sp_q - SP_ONE;
    assign top_o   = mem_q[top_idx];
    assign empty_o = cnt_q == '0;
    assign full_o  = cnt_q == CNT_MAX;
    always_comb begin
        do_pop      = pop_i && !empty_o;
        underflow_o = pop_i && empty_o;
        overflow_o  = push_i && !do_pop && full_o;
        sp_d        = sp_q;
        cnt_d       = cnt_q;
        // Pop+push in one cycle replaces the top in place, leaving sp and count alone.
        if (do_pop && !push_i) begin
            sp_d  = top_idx;
            cnt_d = cnt_q - CNT_ONE;
        end else if (push_i && !do_pop) begin
            sp_d  = sp_q + SP_ONE;
            cnt_d = full_o ? cnt_q : cnt_q + CNT_ONE;
        end
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            sp_q  <= '0;
            cnt_q <= '0;
        end else begin
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
        end
    end
    // Storage needs no reset: entries are only visible through a nonzero count.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[do_pop ? top_idx : sp_q] <= push_data_i;
    end
endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter with next-PC select, return-address stack and external load.
// Ports: clk, reset (sync, active-low), pc_wre commit strobe, pc_src select,
//        imm/jtarget/rs_val target sources, call (push return address),
//        load_en/load_pc priority load, o_pc registered PC, o_pc_plus4,
//        ras_empty/ras_full stack status, err_flags sticky {misalign, underflow, overflow}.
module pc_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pc_wre,
    input  logic [2:0]       pc_src,
    input  logic [WIDTH-1:0] imm,
    input  logic [25:0]      jtarget,
    input  logic [WIDTH-1:0] rs_val,
    input  logic             call,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_pc,
    output logic [WIDTH-1:0] o_pc,
    output logic [WIDTH-1:0] o_pc_plus4,
    output logic             ras_empty,
    output logic             ras_full,
    output logic [2:0]       err_flags
);
    // Jump field covers the low 28 address bits; upper bits come from pc+4.
    localparam logic [WIDTH-1:0] JMP_MASK = WIDTH'(28'hFFF_FFFF);
    logic [WIDTH-1:0] pc_q, pc_d, pc4, br_tgt, jmp_tgt, sel_tgt, tgt, ras_top;
    logic [2:0] err_q, err_d;
    logic commit, push, pop, ras_ovf, ras_udf;
    assign pc4        = pc_q + WIDTH'(4);
    assign br_tgt     = pc4 + (imm << 2);
    assign jmp_tgt    = (pc4 & ~JMP_MASK) | WIDTH'({jtarget, 2'b00});
    assign o_pc       = pc_q;
    assign o_pc_plus4 = pc4;
    assign err_flags  = err_q;
    always_comb begin
        commit  = pc_wre && !load_en;
        push    = commit && call;
        pop     = commit && pc_src == PC_SRC_RET;
        sel_tgt = pc_src == PC_SRC_BR  ? br_tgt  :
                  pc_src == PC_SRC_JMP ? jmp_tgt :
                  pc_src == PC_SRC_REG ? rs_val  :
                  pc_src == PC_SRC_RET ? (ras_empty ? pc4 : ras_top) : pc4;
        tgt     = load_en ? load_pc : sel_tgt;
        pc_d    = pc_q;
        err_d   = err_q;
        if (load_en || pc_wre) begin
            pc_d                = {tgt[WIDTH-1:2], 2'b00};
            err_d[ERR_MISALIGN] = err_q[ERR_MISALIGN] | (tgt[1:0] != 2'b00);
        end
        err_d[ERR_UNDERFLOW] = err_d[ERR_UNDERFLOW] | ras_udf;
        err_d[ERR_OVERFLOW]  = err_d[ERR_OVERFLOW] | ras_ovf;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q  <= RESET_VECTOR;
            err_q <= '0;
        end else begin
            pc_q  <= pc_d;
            err_q <= err_d;
        end
    end
    pc_ras #(.DEPTH(RAS_DEPTH), .WIDTH(WIDTH)) u_ras (
        .clk        (clk),
        .reset      (reset),
        .push_i     (push),
        .pop_i      (pop),
        .push_data_i(pc4),
        .top_o      (ras_top),
        .empty_o    (ras_empty),
        .full_o     (ras_full),
        .overflow_o (ras_ovf),
        .underflow_o(ras_udf)
    );
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed self-checking bench for pc_unit.
module tb_pc_unit;
    import pc_pkg::*;
    logic        clk = 1'b0;
    logic        reset, pc_wre, call, load_en;
    logic [2:0]  pc_src;
    logic [31:0] imm, rs_val, load_pc, o_pc, o_pc_plus4;
    logic [25:0] jtarget;
    logic        ras_empty, ras_full;
    logic [2:0]  err_flags;
    int n_cmp = 0;
    int n_bad = 0;
    always #5 clk = ~clk;
    pc_unit #(.WIDTH(32), .RESET_VECTOR(32'h100), .RAS_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .pc_wre(pc_wre), .pc_src(pc_src), .imm(imm),
        .jtarget(jtarget), .rs_val(rs_val), .call(call), .load_en(load_en),
        .load_pc(load_pc), .o_pc(o_pc), .o_pc_plus4(o_pc_plus4),
        .ras_empty(ras_empty), .ras_full(ras_full), .err_flags(err_flags)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
        pc_wre  = 1'b0;
        call    = 1'b0;
        load_en = 1'b0;
        reset   = 1'b1;
    endtask
    task automatic op(input logic [2:0] src, input logic c, input logic [31:0] rs);
        pc_wre = 1'b1;
        pc_src = src;
        call   = c;
        rs_val = rs;
        tick();
    endtask
    task automatic ld(input logic [31:0] v);
        load_en = 1'b1;
        load_pc = v;
        tick();
    endtask
    initial begin
        reset = 1'b0; pc_wre = 1'b0; call = 1'b0; load_en = 1'b0;
        pc_src = PC_SRC_SEQ; imm = '0; rs_val = '0; load_pc = '0; jtarget = '0;
        tick();
        check("rst_pc", o_pc, 32'h100);
        check("rst_pc4", o_pc_plus4, 32'h104);
        check("rst_err", {29'd0, err_flags}, 32'd0);
        check("rst_empty", {31'd0, ras_empty}, 32'd1);
        check("rst_full", {31'd0, ras_full}, 32'd0);
        op(PC_SRC_SEQ, 1'b0, '0);
        check("seq", o_pc, 32'h104);
        imm = -32'sd2;
        op(PC_SRC_BR, 1'b0, '0);
        check("br_neg", o_pc, 32'h100);
        repeat (3) tick();
        check("hold", o_pc, 32'h100);
        op(3'd6, 1'b0, '0);
        check("src6_seq", o_pc, 32'h104);
        ld(32'h200);
        check("load", o_pc, 32'h200);
        jtarget = 26'h40;
        op(PC_SRC_JMP, 1'b1, '0);
        check("jmp_call", o_pc, 32'h100);
        check("jmp_nonempty", {31'd0, ras_empty}, 32'd0);
        op(PC_SRC_RET, 1'b0, '0);
        check("ret", o_pc, 32'h204);
        check("ret_empty", {31'd0, ras_empty}, 32'd1);
        for (int k = 1; k <= 4; k++) op(PC_SRC_REG, 1'b1, k * 32'h1000);
        check("call4_full", {31'd0, ras_full}, 32'd1);
        check("call4_err", {29'd0, err_flags}, 32'd0);
        op(PC_SRC_REG, 1'b1, 32'h5000);
        check("call5_pc", o_pc, 32'h5000);
        check("ovf_full", {31'd0, ras_full}, 32'd1);
        check("ovf_err", {29'd0, err_flags}, 32'b001);
        for (int k = 4; k >= 1; k--) begin
            op(PC_SRC_RET, 1'b0, '0);
            check($sformatf("lifo%0d", k), o_pc, k * 32'h1000 + 32'h4);
        end
        check("lifo_empty", {31'd0, ras_empty}, 32'd1);
        op(PC_SRC_RET, 1'b0, '0);
        check("udf_pc", o_pc, 32'h1008);
        check("udf_err", {29'd0, err_flags}, 32'b011);
        op(PC_SRC_REG, 1'b1, 32'h500);
        pc_wre = 1'b1; pc_src = PC_SRC_SEQ; call = 1'b1;
        ld(32'h303);
        check("load_mis_pc", o_pc, 32'h300);
        check("load_mis_err", {29'd0, err_flags}, 32'b111);
        check("load_ras_kept", {30'd0, ras_empty, ras_full}, 32'd0);
        op(PC_SRC_RET, 1'b0, '0);
        check("load_ras_top", o_pc, 32'h100C);
        ld(32'hFFFF_FFFC);
        op(PC_SRC_SEQ, 1'b0, '0);
        check("wrap", o_pc, 32'h0);
        op(PC_SRC_REG, 1'b1, 32'h40);
        check("pre_rst_nonempty", {31'd0, ras_empty}, 32'd0);
        reset = 1'b0; pc_wre = 1'b1; load_en = 1'b1; load_pc = 32'h800;
        tick();
        check("rst2_pc", o_pc, 32'h100);
        check("rst2_err", {29'd0, err_flags}, 32'd0);
        check("rst2_empty", {31'd0, ras_empty}, 32'd1);
        op(PC_SRC_RET, 1'b0, '0);
        check("rst2_ret", o_pc, 32'h104);
        check("rst2_udf", {29'd0, err_flags}, 32'b010);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
